// File: rtl/line_window_ctrl.sv
// line_window_ctrl: video qualifier, position counters, shift-RAM drive
// and sync delay for a two-line 3x3 window buffer.
//
// Ports:
//   clock, rst_n                    clock / async active-low reset
//   per_frame_vsync/href/clken      incoming frame, line and pixel strobes
//   per_img_data                    incoming pixel
//   ram_clken, ram_shiftin          registered shift-RAM chain drive
//   col_cnt, row_cnt                position of the current accepted pixel
//   post_frame_vsync/href/clken     syncs delayed by PIPE_DLY cycles
//   win_valid                       3x3 window fully inside the image
//   len_err                         sticky line-length error
module line_window_ctrl #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int DATA_WIDTH = 8,
  parameter int PIPE_DLY   = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_data,
  output logic                  ram_clken,
  output logic [DATA_WIDTH-1:0] ram_shiftin,
  output logic [10:0]           col_cnt,
  output logic [10:0]           row_cnt,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic                  win_valid,
  output logic                  len_err
);

  localparam logic [10:0] H = 11'(IMG_H_DISP);
  localparam logic [10:0] V = 11'(IMG_V_DISP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic        vsync_q;
  logic        href_q;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic [10:0] row_inc;
  logic        err_q, err_d;

  logic                  ram_en_q;
  logic [DATA_WIDTH-1:0] ram_dat_q;

  // Pipe lanes: [3]=window, [2]=accept, [1]=href, [0]=vsync
  logic [PIPE_DLY-1:0][3:0] pipe_q;
  logic [PIPE_DLY-1:0][3:0] pipe_d;
  logic [3:0]               pipe_in;

  logic active;
  logic frame_start;
  logic line_end;
  logic strobe;
  logic accept;
  logic overrun;
  logic win_raw;

  assign active      = (state_q == FILL) || (state_q == RUN);
  assign frame_start = per_frame_vsync & ~vsync_q;
  assign line_end    = href_q & ~per_frame_href;
  assign strobe      = per_frame_href & per_frame_clken & active;
  assign accept      = strobe & (col_q < H);
  // col_q never exceeds H, so equality marks an overlong line
  assign overrun     = strobe & (col_q == H);
  assign win_raw     = accept & (row_q >= 11'd2)
                     & (col_q >= 11'd2);
  assign row_inc     = row_q + 11'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    if (frame_start) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (accept)  col_d = col_q + 11'd1;
      if (overrun) err_d = 1'b1;
      // an href with no accepted pixels is not a line
      if (line_end && active && col_q != '0) begin
        if (col_q != H) err_d = 1'b1;
        col_d = '0;
        row_d = row_inc;
        if (row_inc == V)       state_d = DONE;
        else if (row_inc == 11'd2) state_d = RUN;
      end
    end
  end

  assign pipe_in = {win_raw, accept,
                    per_frame_href, per_frame_vsync};

  if (PIPE_DLY > 1) begin : g_pipe
    assign pipe_d = {pipe_q[PIPE_DLY-2:0], pipe_in};
  end else begin : g_pipe1
    assign pipe_d = pipe_in;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_dat_q <= '0;
      pipe_q    <= '0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= per_frame_vsync;
      href_q   <= per_frame_href;
      col_q    <= col_d;
      row_q    <= row_d;
      err_q    <= err_d;
      ram_en_q <= accept;
      if (accept) ram_dat_q <= per_img_data;
      pipe_q   <= pipe_d;
    end
  end

  assign ram_clken        = ram_en_q;
  assign ram_shiftin      = ram_dat_q;
  assign col_cnt          = col_q;
  assign row_cnt          = row_q;
  assign len_err          = err_q;
  assign post_frame_vsync = pipe_q[PIPE_DLY-1][0];
  assign post_frame_href  = pipe_q[PIPE_DLY-1][1];
  assign post_frame_clken = pipe_q[PIPE_DLY-1][2];
  assign win_valid        = pipe_q[PIPE_DLY-1][3]
                          & pipe_q[PIPE_DLY-1][2];

endmodule
